pci_bus_arbiter: RTL and testbench
==================================

Name: pci_bus_arbiter

Overview:
Central PCI bus arbiter upstream of every Device instance. It samples the active-low REQ lines from all devices and drives their active-low GNT lines; a device's master scope starts on the falling edge of its GNT. Selection is round-robin. The arbiter tracks FRAME/IRDY to know when the shared bus is busy, and reclaims grants that are never used.

Parameters:
NUM_DEV, 4, number of requesting devices (legal range 2..8)
OWNER_W, 2, width of owner index; localparam = $clog2(NUM_DEV)
GRANT_TIMEOUT, 16, cycles GNT may stay asserted without FRAME going low before the grant is revoked (legal range 2..255)

Ports:
CLK  input  1  bus clock; all state updates on posedge
RST  input  1  asynchronous, active-high reset
REQ  input  NUM_DEV  active-low request, one bit per device
FRAME  input  1  shared PCI FRAME, active-low
IRDY  input  1  shared PCI IRDY, active-low
GNT  output  NUM_DEV  active-low grant, one-hot-low or all ones, registered
OWNER  output  OWNER_W  index of the device currently granted or owning the bus
OWNER_VALID  output  1  high while OWNER is meaningful (GRANT or BUSY state)
TIMEOUT_EVT  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (RST high, asynchronous): GNT all ones, OWNER=0, OWNER_VALID=0, TIMEOUT_EVT=0, state IDLE, round-robin pointer=0, timeout counter=0. Reset mid-transaction drops GNT immediately and does not wait for the bus.
- Bus idle = FRAME=1 and IRDY=1 at the sampling edge. No hidden arbitration: a new grant is issued only from IDLE with the bus idle.
- Round-robin: the search starts at pointer and wraps modulo NUM_DEV. The first index with REQ=0 wins. After any grant to device k, pointer becomes (k+1) mod NUM_DEV. The pointer also advances this way when a grant is revoked.
- At most one GNT bit is low at any time. GNT, OWNER and OWNER_VALID are registered and change only on posedge CLK.
- States:
  - IDLE: GNT all ones, OWNER_VALID=0.
    - If the bus is idle and any REQ=0, go to GRANT next cycle: winner's GNT=0, OWNER=winner, OWNER_VALID=1, counter=0.
    - If the bus is not idle (a foreign or stale transaction is running), stay in IDLE.
  - GRANT: the counter increments each cycle.
    - FRAME=0 sampled: go to BUSY, set GNT all ones on the same edge, and keep OWNER.
    - Else, if REQ[OWNER]=1 (request withdrawn): GNT all ones, go to IDLE.
    - Else, if counter reaches GRANT_TIMEOUT-1: GNT all ones, TIMEOUT_EVT=1 for one cycle, go to IDLE.
    - Priority among these three: FRAME over withdrawal over timeout.
  - BUSY: OWNER_VALID=1 and GNT all ones. Stay until FRAME=1 and IRDY=1 are sampled together, then go to TURNAROUND.
  - TURNAROUND: exactly one cycle with GNT all ones and OWNER_VALID=0, then go to IDLE. Earliest next GNT is therefore 2 cycles after the bus goes idle.
- Latency: from REQ falling with the bus idle in IDLE, GNT falls on the next posedge (1 cycle).
- REQ changes by non-owners are ignored outside IDLE. A device re-requesting while it is the owner is served only after the other requesters in round-robin order.
- Simultaneous requests are resolved purely by the pointer. No fixed priority.
- FRAME=0 while in IDLE (no grant issued) is treated as a busy bus. The arbiter stays in IDLE with no error output.

Test Plan:
- Single requester: after reset, REQ=4'b1011 with the bus idle → GNT=4'b1011 one cycle later, OWNER=2; then FRAME=0 → GNT=4'b1111 next edge, state BUSY, OWNER_VALID=1.
- Round-robin fairness: REQ=4'b0000 held, each grantee runs a 3-cycle transaction → grant order 0,1,2,3,0, with exactly one TURNAROUND cycle between FRAME/IRDY returning high and the next GNT.
- Timeout: REQ[1]=0, FRAME never asserted, GRANT_TIMEOUT=16 → GNT[1] low for exactly 16 cycles; TIMEOUT_EVT pulses one cycle as GNT returns to 1111; the next grant goes to device 2 if it is requesting.
- Request withdrawal: REQ[3] goes 0 then back to 1 two cycles after its GNT → GNT all ones next edge, no TIMEOUT_EVT, state IDLE.
- Busy bus blocks grant: FRAME=0 and IRDY=0 driven externally in IDLE with REQ[0]=0 → GNT stays 1111 until both are high, then GNT[0]=0 one cycle later.
- Async reset mid-BUSY: assert RST between clock edges → GNT=1111, OWNER=0, OWNER_VALID=0 immediately, without waiting for an edge; after release with REQ=4'b1110 → GNT=4'b1110 on the first edge.

Source files
------------

// File: rtl/pci_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter_if
// Groups the shared PCI arbitration signals between the central arbiter and
// the requesting devices (plus the shared FRAME/IRDY bus status lines).
//
// Signals:
//   REQ          devices -> arbiter  active-low request, one bit per device
//   FRAME        bus     -> arbiter  shared PCI FRAME, active-low
//   IRDY         bus     -> arbiter  shared PCI IRDY, active-low
//   GNT          arbiter -> devices  active-low grant, one-hot-low or all ones
//   OWNER        arbiter -> devices  index of the granted / owning device
//   OWNER_VALID  arbiter -> devices  OWNER is meaningful (grant or bus owned)
//   TIMEOUT_EVT  arbiter -> devices  one-cycle pulse on grant revocation
//
// Modports:
//   master  the arbiter side (drives GNT and the owner status)
//   slave   the device/bus side (drives REQ, FRAME, IRDY)
// -----------------------------------------------------------------------------
interface pci_bus_arbiter_if #(
   parameter int NUM_DEV = 4
);
   localparam int OWNER_W = $clog2(NUM_DEV);

   logic [NUM_DEV-1:0] REQ;
   logic               FRAME;
   logic               IRDY;
   logic [NUM_DEV-1:0] GNT;
   logic [OWNER_W-1:0] OWNER;
   logic               OWNER_VALID;
   logic               TIMEOUT_EVT;

   modport master (
      input  REQ, FRAME, IRDY,
      output GNT, OWNER, OWNER_VALID, TIMEOUT_EVT
   );

   modport slave (
      output REQ, FRAME, IRDY,
      input  GNT, OWNER, OWNER_VALID, TIMEOUT_EVT
   );
endinterface

// File: rtl/pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter
// Central round-robin PCI bus arbiter. Samples the active-low REQ lines and
// issues at most one active-low GNT at a time, only while the shared bus is
// idle (no hidden arbitration). Watches FRAME/IRDY to follow the owner's
// transaction, inserts one turnaround cycle after the bus goes idle, and
// revokes grants that are not used within GRANT_TIMEOUT cycles.
//
// Ports:
//   CLK   bus clock, all state changes on its rising edge
//   RST   asynchronous active-high reset
//   bus   pci_bus_arbiter_if.master : REQ/FRAME/IRDY in, GNT/OWNER/
//         OWNER_VALID/TIMEOUT_EVT out (all outputs registered)
// -----------------------------------------------------------------------------
module pci_bus_arbiter #(
   parameter int NUM_DEV       = 4,
   parameter int GRANT_TIMEOUT = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   pci_bus_arbiter_if.master       bus
);

   localparam int OWNER_W = $clog2(NUM_DEV);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_BUSY,
      ST_TURNAROUND
   } state_t;

   state_t               state_q,       state_d;
   logic [NUM_DEV-1:0]   gnt_q,         gnt_d;
   logic [OWNER_W-1:0]   owner_q,       owner_d;
   logic                 owner_valid_q, owner_valid_d;
   logic                 timeout_evt_q, timeout_evt_d;
   logic [OWNER_W-1:0]   ptr_q,         ptr_d;
   logic [7:0]           cnt_q,         cnt_d;

   logic                 bus_idle;
   logic                 any_req;
   logic [OWNER_W-1:0]   winner;
   logic [OWNER_W-1:0]   idx_w;
   int                   idx;

   // Index following k, wrapping at NUM_DEV (also correct for non power-of-two
   // device counts).
   function automatic logic [OWNER_W-1:0] next_index(input logic [OWNER_W-1:0] k);
      return OWNER_W'((int'(k) + 1) % NUM_DEV);
   endfunction

   assign bus_idle = bus.FRAME & bus.IRDY;

   // Round-robin search. Walking the offsets from the far end back towards the
   // pointer lets the closest requester overwrite earlier candidates, so the
   // first requester at or after the pointer wins without a break statement.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      idx     = 0;
      idx_w   = '0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         idx   = (int'(ptr_q) + i) % NUM_DEV;
         idx_w = OWNER_W'(idx);
         if (!bus.REQ[idx_w]) begin
            any_req = 1'b1;
            winner  = idx_w;
         end
      end
   end

   // Next-state and registered-output logic. The outputs are computed one
   // edge ahead so GNT/OWNER/OWNER_VALID come straight from flops. The
   // pointer already moves past the winner when the grant is issued, so a
   // revoked or withdrawn grant leaves it pointing at the next device.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      timeout_evt_d = 1'b0;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            gnt_d         = '1;
            owner_valid_d = 1'b0;
            if (bus_idle && any_req) begin
               state_d       = ST_GRANT;
               gnt_d         = ~(NUM_DEV'(1) << winner);
               owner_d       = winner;
               owner_valid_d = 1'b1;
               cnt_d         = '0;
               ptr_d         = next_index(winner);
            end
         end

         ST_GRANT: begin
            if (!bus.FRAME) begin
               state_d       = ST_BUSY;
               gnt_d         = '1;
               owner_valid_d = 1'b1;
            end else if (bus.REQ[owner_q]) begin
               state_d       = ST_IDLE;
               gnt_d         = '1;
               owner_valid_d = 1'b0;
               ptr_d         = next_index(owner_q);
            end else if (cnt_q == 8'(GRANT_TIMEOUT - 1)) begin
               state_d       = ST_IDLE;
               gnt_d         = '1;
               owner_valid_d = 1'b0;
               timeout_evt_d = 1'b1;
               ptr_d         = next_index(owner_q);
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_BUSY: begin
            gnt_d         = '1;
            owner_valid_d = 1'b1;
            if (bus_idle) begin
               state_d       = ST_TURNAROUND;
               owner_valid_d = 1'b0;
            end
         end

         ST_TURNAROUND: begin
            gnt_d         = '1;
            owner_valid_d = 1'b0;
            state_d       = ST_IDLE;
         end

         default: begin
            state_d       = ST_IDLE;
            gnt_d         = '1;
            owner_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset releases the bus immediately, without
   // waiting for any transaction in flight to finish.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         gnt_q         <= '1;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         timeout_evt_q <= 1'b0;
         ptr_q         <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         timeout_evt_q <= timeout_evt_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.GNT         = gnt_q;
   assign bus.OWNER       = owner_q;
   assign bus.OWNER_VALID = owner_valid_q;
   assign bus.TIMEOUT_EVT = timeout_evt_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pci_bus_arbiter
// Scoreboard bench for pci_bus_arbiter. Inputs are driven on the falling
// clock edge; each time they are driven a reference model predicts the
// outputs after the following rising edge and queues that prediction. A
// separate monitor pops one prediction per rising edge (sampled 1 ns later)
// and compares it with the DUT. Directed sequences cover the listed scenarios,
// followed by randomized device behaviour and an asynchronous reset mid-BUSY.
// -----------------------------------------------------------------------------
module tb_pci_bus_arbiter;

   localparam int NUM_DEV       = 4;
   localparam int GRANT_TIMEOUT = 16;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       ov;
      logic       tevt;
   } snap_t;

   logic CLK;
   logic RST;

   pci_bus_arbiter_if #(.NUM_DEV(NUM_DEV)) bus ();

   pci_bus_arbiter #(
      .NUM_DEV      (NUM_DEV),
      .GRANT_TIMEOUT(GRANT_TIMEOUT)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int    checks   = 0;
   int    failures = 0;
   bit    started  = 1'b0;
   snap_t exp_q[$];

   // Reference model: who holds GNT (-1 none), who is using the bus (-1 none),
   // whether a turnaround cycle is pending, how many cycles the current grant
   // has been visible, the last owner reported, and the round-robin start.
   int m_gnt_dev;
   int m_busy_dev;
   bit m_tar;
   int m_held;
   int m_owner;
   int m_ptr;
   bit m_tevt;

   // Bench-side device behaviour state
   int txn_frame;
   int txn_irdy;
   bit plan_active;
   int plan_mode;
   int plan_delay;

   // Clock generation
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model reset
   task automatic modelReset();
      m_gnt_dev  = -1;
      m_busy_dev = -1;
      m_tar      = 1'b0;
      m_held     = 0;
      m_owner    = 0;
      m_ptr      = 0;
      m_tevt     = 1'b0;
   endtask

   // Advances the model by one rising edge with the inputs that edge samples
   task automatic modelStep(input logic rst, input logic [3:0] req,
                            input logic frame, input logic irdy);
      bit idle;
      int d;
      if (rst) begin
         modelReset();
         return;
      end
      idle   = frame && irdy;
      m_tevt = 1'b0;
      if (m_gnt_dev >= 0) begin
         if (!frame) begin
            m_busy_dev = m_gnt_dev;
            m_gnt_dev  = -1;
         end else if (req[m_gnt_dev]) begin
            m_gnt_dev = -1;
         end else if (m_held == GRANT_TIMEOUT) begin
            m_tevt    = 1'b1;
            m_gnt_dev = -1;
         end else begin
            m_held++;
         end
      end else if (m_busy_dev >= 0) begin
         if (idle) begin
            m_busy_dev = -1;
            m_tar      = 1'b1;
         end
      end else if (m_tar) begin
         m_tar = 1'b0;
      end else if (idle) begin
         for (int k = 0; k < NUM_DEV; k++) begin
            d = (m_ptr + k) % NUM_DEV;
            if (!req[d]) begin
               m_gnt_dev = d;
               m_owner   = d;
               m_ptr     = (d + 1) % NUM_DEV;
               m_held    = 1;
               break;
            end
         end
      end
   endtask

   function automatic snap_t modelSnap();
      snap_t s;
      logic [3:0] one;
      one    = 4'b0001;
      s.ov   = (m_gnt_dev >= 0) || (m_busy_dev >= 0);
      s.gnt  = (m_gnt_dev >= 0) ? ~(one << m_gnt_dev) : 4'b1111;
      s.owner = s.ov ? 2'(m_owner) : 2'd0;
      s.tevt = m_tevt;
      return s;
   endfunction

   // Drives one cycle of inputs on the falling edge and queues the prediction
   task automatic applyStimulus(input logic rst, input logic [3:0] req,
                                input logic frame, input logic irdy);
      @(negedge CLK);
      RST       = rst;
      bus.REQ   = req;
      bus.FRAME = frame;
      bus.IRDY  = irdy;
      modelStep(rst, req, frame, irdy);
      exp_q.push_back(modelSnap());
      started = 1'b1;
   endtask

   task automatic checkValue(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Compares the DUT outputs with the oldest queued prediction
   task automatic checkOutput();
      snap_t e;
      snap_t a;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_empty t=%0t", $time);
         return;
      end
      e       = exp_q.pop_front();
      a.gnt   = bus.GNT;
      a.ov    = bus.OWNER_VALID;
      a.owner = bus.OWNER_VALID ? bus.OWNER : 2'd0;
      a.tevt  = bus.TIMEOUT_EVT;
      if (a !== e) begin
         failures++;
         $display("[TB] FAIL cycle_outputs t=%0t actual gnt=%b owner=%0d ov=%b tevt=%b required gnt=%b owner=%0d ov=%b tevt=%b",
                  $time, a.gnt, a.owner, a.ov, a.tevt, e.gnt, e.owner, e.ov, e.tevt);
      end
   endtask

   // Monitor: one comparison per rising edge once stimulus has begun
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (started) checkOutput();
      end
   end

   // Main stimulus sequence
   initial begin
      logic [3:0] r;
      logic       f;
      logic       i;

      RST         = 1'b1;
      bus.REQ     = 4'b1111;
      bus.FRAME   = 1'b1;
      bus.IRDY    = 1'b1;
      txn_frame   = 0;
      txn_irdy    = 0;
      plan_active = 1'b0;
      plan_mode   = 0;
      plan_delay  = 0;
      modelReset();

      repeat (2) @(posedge CLK);
      #1;
      checkValue("reset_gnt",  int'(bus.GNT), 15);
      checkValue("reset_owner", int'(bus.OWNER), 0);
      checkValue("reset_owner_valid", int'(bus.OWNER_VALID), 0);
      checkValue("reset_timeout_evt", int'(bus.TIMEOUT_EVT), 0);

      // Single requester, then its transaction and the turnaround
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1011, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);

      // Foreign traffic blocks the grant, then withdrawal
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1110, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1110, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);

      // Timeout on device 1 while device 2 also waits
      for (int c = 0; c < GRANT_TIMEOUT + 2; c++)
         applyStimulus(1'b0, 4'b1001, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);

      // All devices requesting with short transactions
      for (int c = 0; c < 40; c++) begin
         f = 1'b1;
         i = 1'b1;
         if (m_gnt_dev >= 0 || (m_busy_dev >= 0 && txn_frame > 0)) begin
            if (m_gnt_dev >= 0) txn_frame = 3;
            f = 1'b0;
            txn_frame--;
         end
         applyStimulus(1'b0, 4'b0000, f, i);
      end

      // Randomized device behaviour
      for (int c = 0; c < 3000; c++) begin
         r = 4'($urandom_range(0, 15));
         f = 1'b1;
         i = 1'b1;
         if (m_gnt_dev < 0) plan_active = 1'b0;
         if (txn_frame == 0 && txn_irdy == 0) begin
            if (m_gnt_dev >= 0) begin
               if (!plan_active) begin
                  plan_active = 1'b1;
                  plan_mode   = int'($urandom_range(0, 2));
                  plan_delay  = int'($urandom_range(0, 3));
               end
               r[m_gnt_dev] = 1'b0;
               if (plan_delay > 0) begin
                  plan_delay--;
               end else if (plan_mode == 0) begin
                  txn_frame = int'($urandom_range(1, 4));
                  txn_irdy  = int'($urandom_range(0, 2));
               end else if (plan_mode == 1) begin
                  r[m_gnt_dev] = 1'b1;
               end
            end else if (m_busy_dev < 0 && $urandom_range(0, 11) == 0) begin
               txn_frame = int'($urandom_range(1, 2));
               txn_irdy  = int'($urandom_range(0, 1));
            end
         end
         if (txn_frame > 0) begin
            f = 1'b0;
            i = 1'($urandom_range(0, 1));
            txn_frame--;
         end else if (txn_irdy > 0) begin
            i = 1'b0;
            txn_irdy--;
         end
         applyStimulus(1'b0, r, f, i);
      end
      txn_frame = 0;
      txn_irdy  = 0;

      // Asynchronous reset in the middle of a transaction
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1110, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b1110, 1'b0, 1'b0);
      #1;
      checkValue("async_reset_gnt", int'(bus.GNT), 15);
      checkValue("async_reset_owner", int'(bus.OWNER), 0);
      checkValue("async_reset_owner_valid", int'(bus.OWNER_VALID), 0);
      applyStimulus(1'b0, 4'b1110, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);

      @(posedge CLK);
      #2;
      checkValue("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
